up_count_monitor: RTL and testbench

//  Downstream checker for the free-running up counter. Samples the counter value and
//  the counter's own sync reset every clock, and verifies each step is +1 mod 2^CNT_W
//  (or 0 after a counter reset). Counts wrap-arounds and flags illegal transitions.

---
 rtl/up_count_monitor_pkg.sv | 11 +
 rtl/up_count_monitor_if.sv | 10 +
 rtl/up_count_monitor_evt_fifo2.sv | 49 ++++
 rtl/up_count_monitor.sv | 118 +++++++++++
 tb/tb_up_count_monitor.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/up_count_monitor_pkg.sv
// Shared types and default widths for the up-counter monitor.
package up_count_pkg;
  localparam int CNT_W_DEF  = 3;
  localparam int WRAP_W_DEF = 8;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;
endpackage

// File: rtl/up_count_monitor_if.sv
// Wrap-event stream from the monitor (master) to its consumer (slave).
interface up_count_monitor_if #(parameter int WIDTH = 8);
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_data;
  logic             evt_ovf;

  modport master (output evt_valid, output evt_data, output evt_ovf, input evt_ready);
  modport slave  (input evt_valid, input evt_data, input evt_ovf, output evt_ready);
endinterface

// File: rtl/up_count_monitor_evt_fifo2.sv
// Two-entry FIFO; a push into a full FIFO is accepted only if a pop happens alongside.
module evt_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic [1:0]       r_cnt;
  logic             w_do_pop;
  logic             w_do_push;
  logic             w_wr_head;

  assign w_do_pop  = pop & (r_cnt != 2'd0);
  assign w_do_push = push & ((r_cnt != 2'd2) | w_do_pop);
  // After the shift on pop, the free slot is the head when only one entry was in flight.
  assign w_wr_head = (r_cnt == {1'b0, w_do_pop});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_cnt  <= 2'd0;
    end else if (clr) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_do_pop) r_mem0 <= r_mem1;
      if (w_do_push) begin
        if (w_wr_head) r_mem0 <= din;
        else           r_mem1 <= din;
      end
      r_cnt <= r_cnt + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign dout  = r_mem0;
  assign full  = (r_cnt == 2'd2);
  assign empty = (r_cnt == 2'd0);
endmodule

// File: rtl/up_count_monitor.sv
// Checks that a free-running counter steps by +1 (or to 0 after its own reset),
// counts wraps, latches the first illegal step and queues one event per wrap.
module up_count_monitor
  import up_count_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  q_in,
  input  logic              cnt_rst_in,
  input  logic              clr,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err,
  output logic [CNT_W-1:0]  err_exp,
  output logic [CNT_W-1:0]  err_act,
  up_count_monitor_if.master evt
);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_prev;
  logic              r_exp_rst;
  logic              r_ovf;
  logic [CNT_W-1:0]  w_exp;
  logic              w_mismatch;
  logic              w_wrap;
  logic [WRAP_W-1:0] w_count_nxt;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [WRAP_W-1:0] w_head;

  assign w_exp       = r_exp_rst ? '0 : r_prev + CNT_W'(1);
  assign w_count_nxt = (wrap_count == WRAP_MAX) ? wrap_count : wrap_count + WRAP_W'(1);
  assign w_pop       = evt.evt_valid & evt.evt_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= SYNC;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mismatch  = 1'b0;
    w_wrap      = 1'b0;
    if (clr) begin
      w_state_nxt = SYNC;
    end else begin
      case (r_state)
        SYNC:  w_state_nxt = TRACK;
        TRACK: begin
          if (q_in != w_exp) begin
            w_mismatch  = 1'b1;
            w_state_nxt = ERROR;
          end else if ((r_prev == CNT_MAX) && !r_exp_rst && (q_in == '0)) begin
            w_wrap = 1'b1;
          end
        end
        ERROR:   w_state_nxt = ERROR;
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev     <= '0;
      r_exp_rst  <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      err        <= 1'b0;
      err_exp    <= '0;
      err_act    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_prev    <= q_in;
      r_exp_rst <= cnt_rst_in;
      if (clr) begin
        wrap_pulse <= 1'b0;
        wrap_count <= '0;
        err        <= 1'b0;
        err_exp    <= '0;
        err_act    <= '0;
        r_ovf      <= 1'b0;
      end else begin
        wrap_pulse <= w_wrap;
        if (w_wrap) wrap_count <= w_count_nxt;
        if (w_mismatch) begin
          err     <= 1'b1;
          err_exp <= w_exp;
          err_act <= q_in;
        end
        if (w_wrap && w_full && !w_pop) r_ovf <= 1'b1;
      end
    end
  end

  evt_fifo2 #(.WIDTH(WRAP_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (w_wrap),
    .pop   (w_pop),
    .din   (w_count_nxt),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign evt.evt_valid = !w_empty;
  assign evt.evt_data  = w_head;
  assign evt.evt_ovf   = r_ovf;
endmodule

// File: tb/tb_up_count_monitor.sv
// Directed bench for up_count_monitor: 8-bit wrap counter instance plus a 2-bit one for saturation.
module tb_up_count_monitor;
  logic       clk;
  logic       rst;
  logic [2:0] q_in;
  logic       cnt_rst_in;
  logic       clr;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic       err;
  logic [2:0] err_exp;
  logic [2:0] err_act;
  logic       wp2;
  logic [1:0] wc2;
  logic       e2;
  logic [2:0] ee2;
  logic [2:0] ea2;
  logic [2:0] cq;
  int checks;
  int failures;

  up_count_monitor_if #(.WIDTH(8)) evt_if ();
  up_count_monitor_if #(.WIDTH(2)) evt_if2 ();

  up_count_monitor #(.CNT_W(3), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .cnt_rst_in(cnt_rst_in), .clr(clr),
    .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .err(err),
    .err_exp(err_exp), .err_act(err_act), .evt(evt_if)
  );

  up_count_monitor #(.CNT_W(3), .WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .q_in(q_in), .cnt_rst_in(cnt_rst_in), .clr(clr),
    .wrap_pulse(wp2), .wrap_count(wc2), .err(e2),
    .err_exp(ee2), .err_act(ea2), .evt(evt_if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // Called at posedge+1; applies inputs, then returns 1 time unit after the next edge.
  task automatic step(input logic [2:0] q, input logic r, input logic c);
    q_in = q; cnt_rst_in = r; clr = c; cq = q;
    @(posedge clk); #1;
  endtask

  task automatic tick();
    step(cq + 3'd1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; q_in = 3'd0; cnt_rst_in = 1'b0; clr = 1'b0; cq = 3'd0;
    evt_if.evt_ready = 1'b1; evt_if2.evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({wrap_pulse, wrap_count, err, err_exp, err_act} !== 16'd0) begin failures++; $display("FAIL reset_outs act=%h exp=0", {wrap_pulse, wrap_count, err, err_exp, err_act}); end
    checks++; if ({evt_if.evt_valid, evt_if.evt_ovf, evt_if.evt_data} !== 10'd0) begin failures++; $display("FAIL reset_evt act=%h exp=0", {evt_if.evt_valid, evt_if.evt_ovf, evt_if.evt_data}); end
    rst = 1'b1;
  endtask

  task automatic test_free_run();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(3'(i % 8), 1'b0, 1'b0);
      checks++; if (wrap_pulse !== ((i >= 8) && (i % 8 == 0))) begin failures++; $display("FAIL run_pulse i=%0d act=%b exp=%b", i, wrap_pulse, ((i >= 8) && (i % 8 == 0))); end
      if (wrap_pulse === 1'b1) pulses++;
      if (i == 8) begin
        checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'd1) begin failures++; $display("FAIL run_evt1 act=%b/%0d exp=1/1", evt_if.evt_valid, evt_if.evt_data); end
      end
      if (i == 16) begin
        checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'd2) begin failures++; $display("FAIL run_evt2 act=%b/%0d exp=1/2", evt_if.evt_valid, evt_if.evt_data); end
      end
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL run_pulses act=%0d exp=2", pulses); end
    checks++; if (wrap_count !== 8'd2) begin failures++; $display("FAIL run_count act=%0d exp=2", wrap_count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL run_err act=%b exp=0", err); end
  endtask

  task automatic test_cnt_reset();
    tick();
    step(3'd5, 1'b1, 1'b0);
    step(3'd0, 1'b0, 1'b0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL crst_err act=%b exp=0", err); end
    checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL crst_pulse act=%b exp=0", wrap_pulse); end
    checks++; if (wrap_count !== 8'd2) begin failures++; $display("FAIL crst_count act=%0d exp=2", wrap_count); end
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL crst_err2 act=%b exp=0", err); end
  endtask

  task automatic test_error();
    tick(); tick();
    step(3'd5, 1'b0, 1'b0);
    checks++; if (err !== 1'b1 || err_exp !== 3'd4 || err_act !== 3'd5) begin failures++; $display("FAIL err_latch act=%b/%0d/%0d exp=1/4/5", err, err_exp, err_act); end
    tick(); tick(); tick();
    checks++; if (wrap_pulse !== 1'b0 || wrap_count !== 8'd2) begin failures++; $display("FAIL err_nowrap act=%b/%0d exp=0/2", wrap_pulse, wrap_count); end
    checks++; if (err_exp !== 3'd4 || err_act !== 3'd5) begin failures++; $display("FAIL err_hold act=%0d/%0d exp=4/5", err_exp, err_act); end
    step(3'd1, 1'b0, 1'b1);
    checks++; if (err !== 1'b0 || wrap_count !== 8'd0 || err_exp !== 3'd0 || err_act !== 3'd0) begin failures++; $display("FAIL err_clr act=%b/%0d/%0d/%0d exp=0/0/0/0", err, wrap_count, err_exp, err_act); end
    step(3'd6, 1'b0, 1'b0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_sync act=%b exp=0", err); end
    tick(); tick();
    checks++; if (err !== 1'b0 || wrap_pulse !== 1'b1 || wrap_count !== 8'd1) begin failures++; $display("FAIL err_resume act=%b/%b/%0d exp=0/1/1", err, wrap_pulse, wrap_count); end
  endtask

  task automatic test_queue_overflow();
    evt_if.evt_ready = 1'b0;
    step(3'd0, 1'b0, 1'b1);
    for (int w = 1; w <= 3; w++) begin
      repeat (8) tick();
      checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'd1) begin failures++; $display("FAIL ovf_head w=%0d act=%b/%0d exp=1/1", w, evt_if.evt_valid, evt_if.evt_data); end
      checks++; if (evt_if.evt_ovf !== (w == 3)) begin failures++; $display("FAIL ovf_flag w=%0d act=%b exp=%b", w, evt_if.evt_ovf, (w == 3)); end
    end
    checks++; if (wrap_count !== 8'd3) begin failures++; $display("FAIL ovf_count act=%0d exp=3", wrap_count); end
    evt_if.evt_ready = 1'b1;
    tick();
    checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'd2) begin failures++; $display("FAIL ovf_pop1 act=%b/%0d exp=1/2", evt_if.evt_valid, evt_if.evt_data); end
    tick();
    checks++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_ovf !== 1'b1) begin failures++; $display("FAIL ovf_pop2 act=%b/%b exp=0/1", evt_if.evt_valid, evt_if.evt_ovf); end
  endtask

  task automatic test_back_to_back();
    evt_if.evt_ready = 1'b0;
    step(3'd0, 1'b0, 1'b1);
    repeat (16) tick();
    repeat (7) tick();
    evt_if.evt_ready = 1'b1;
    tick();
    checks++; if (evt_if.evt_ovf !== 1'b0 || evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'd2) begin failures++; $display("FAIL b2b_pushpop act=%b/%b/%0d exp=0/1/2", evt_if.evt_ovf, evt_if.evt_valid, evt_if.evt_data); end
    checks++; if (wrap_count !== 8'd3 || wc2 !== 2'd3) begin failures++; $display("FAIL b2b_count act=%0d/%0d exp=3/3", wrap_count, wc2); end
    tick();
    checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'd3) begin failures++; $display("FAIL b2b_third act=%b/%0d exp=1/3", evt_if.evt_valid, evt_if.evt_data); end
    tick();
    checks++; if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty act=%b exp=0", evt_if.evt_valid); end
    repeat (14) tick();
    checks++; if (wrap_count !== 8'd5 || evt_if.evt_ovf !== 1'b0) begin failures++; $display("FAIL b2b_five act=%0d/%b exp=5/0", wrap_count, evt_if.evt_ovf); end
    checks++; if (wc2 !== 2'd3 || wp2 !== 1'b1) begin failures++; $display("FAIL sat_hold act=%0d/%b exp=3/1", wc2, wp2); end
  endtask

  task automatic test_async_reset();
    evt_if.evt_ready = 1'b0;
    step(3'd0, 1'b0, 1'b1);
    repeat (8) tick();
    step(3'd3, 1'b0, 1'b0);
    checks++; if (err !== 1'b1 || err_exp !== 3'd1 || err_act !== 3'd3 || evt_if.evt_valid !== 1'b1) begin failures++; $display("FAIL ar_pre act=%b/%0d/%0d/%b exp=1/1/3/1", err, err_exp, err_act, evt_if.evt_valid); end
    #3 rst = 1'b0;
    #1;
    checks++; if ({wrap_pulse, wrap_count, err, err_exp, err_act} !== 16'd0) begin failures++; $display("FAIL ar_outs act=%h exp=0", {wrap_pulse, wrap_count, err, err_exp, err_act}); end
    checks++; if ({evt_if.evt_valid, evt_if.evt_ovf, evt_if.evt_data} !== 10'd0) begin failures++; $display("FAIL ar_evt act=%h exp=0", {evt_if.evt_valid, evt_if.evt_ovf, evt_if.evt_data}); end
    q_in = 3'd5; cq = 3'd5;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ar_sync act=%b exp=0", err); end
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ar_track act=%b exp=0", err); end
    tick(); tick();
    checks++; if (wrap_pulse !== 1'b1 || wrap_count !== 8'd1 || evt_if.evt_data !== 8'd1) begin failures++; $display("FAIL ar_wrap act=%b/%0d/%0d exp=1/1/1", wrap_pulse, wrap_count, evt_if.evt_data); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_free_run();
    test_cnt_reset();
    test_error();
    test_queue_overflow();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
